// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared definitions for the RTC bus scheduler: FSM states, grant bit
// indices and masks, default timing constants and a small sizing helper.
package rtc_bus_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_DIR,
      ST_GAP,
      ST_DAT,
      ST_CAMBIO,
      ST_RELEASE
   } state_t;

   localparam int GNT_INIT = 0;
   localparam int GNT_ESCR = 1;
   localparam int GNT_LECT = 2;

   localparam logic [2:0] MASK_INIT = 3'b001;
   localparam logic [2:0] MASK_ESCR = 3'b010;
   localparam logic [2:0] MASK_LECT = 3'b100;

   localparam int DEF_T_DIR       = 4;
   localparam int DEF_T_GAP       = 2;
   localparam int DEF_T_DAT       = 4;
   localparam int DEF_READ_PERIOD = 1000;
   localparam int DEF_TIMEOUT     = 256;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rtc_bus_scheduler_periodo_tick.sv
// Free-running periodic read timer: counts 0..READ_PERIOD-1 and flags the
// last count as a one-cycle wrap tick. Pending/overrun bookkeeping lives
// in the scheduler top.
module rtc_bus_scheduler_periodo_tick
   import rtc_bus_scheduler_pkg::*;
#(
   parameter int READ_PERIOD = DEF_READ_PERIOD
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(READ_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(READ_PERIOD - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Advance the period count, folding back to zero after the last value.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
         cnt_d = '0;
      end
   end

   // Period counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// RTC bus scheduler: arbitrates the shared RTC bus between the init, write
// and periodic read clients and sequences the per-register phase strobes.
// Optional grant watchdog enabled by defining RTC_WATCHDOG_EN.
module rtc_bus_scheduler
   import rtc_bus_scheduler_pkg::*;
#(
   parameter int T_DIR       = DEF_T_DIR,
   parameter int T_GAP       = DEF_T_GAP,
   parameter int T_DAT       = DEF_T_DAT,
   parameter int READ_PERIOD = DEF_READ_PERIOD
`ifdef RTC_WATCHDOG_EN
   ,
   parameter int TIMEOUT     = DEF_TIMEOUT
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_init,
   input  logic       req_escr,
   input  logic       term_init,
   input  logic       term_escr,
   input  logic       term_lect,
   output logic [2:0] gnt,
   output logic [2:0] start,
   output logic       dir_ph,
   output logic       dat_ph,
   output logic       cambio_estado,
   output logic       lect_overrun,
   output logic       err_timeout
);

   localparam int SW = $clog2(max3(T_DIR, T_GAP, T_DAT) + 1);
   localparam logic [SW-1:0] LAST_DIR = SW'(T_DIR - 1);
   localparam logic [SW-1:0] LAST_GAP = SW'(T_GAP - 1);
   localparam logic [SW-1:0] LAST_DAT = SW'(T_DAT - 1);

   state_t        state_q, state_d;
   logic [2:0]    gnt_q, gnt_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          lect_pend_q, lect_pend_d;
   logic          lect_overrun_q, lect_overrun_d;

   logic period_tick;
   logic granted;
   logic term_match;
   logic pend_clear;
   logic wd_expire;

   rtc_bus_scheduler_periodo_tick #(
      .READ_PERIOD(READ_PERIOD)
   ) u_periodo_tick (
      .clk  (clk),
      .reset(reset),
      .tick (period_tick)
   );

   assign granted    = (state_q == ST_GRANT) || (state_q == ST_DIR) || (state_q == ST_GAP)
                       || (state_q == ST_DAT) || (state_q == ST_CAMBIO);
   assign term_match = |(gnt_q & {term_lect, term_escr, term_init});
   assign pend_clear = (state_q == ST_GRANT) && gnt_q[GNT_LECT];

`ifdef RTC_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] wd_q, wd_d;
   logic          err_q, err_d;

   // Grant watchdog: counts cycles from GRANT and fires when the limit is hit without a term.
   always_comb begin
      wd_d      = granted ? (wd_q + WW'(1)) : '0;
      wd_expire = granted && (wd_q == WW'(TIMEOUT - 1)) && !term_match;
      err_d     = wd_expire;
   end

   // Watchdog registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err_timeout = err_q;
`else
   assign wd_expire   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Read-pending flag and overrun detection; a wrap in the clearing cycle keeps the flag set.
   always_comb begin
      lect_pend_d = lect_pend_q;
      if (pend_clear) begin
         lect_pend_d = 1'b0;
      end
      if (period_tick) begin
         lect_pend_d = 1'b1;
      end
      lect_overrun_d = period_tick && lect_pend_q && !pend_clear;
   end

   // Arbitration and phase sequencing; a matching term or watchdog expiry always wins.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      slot_d  = slot_q;
      case (state_q)
         ST_IDLE: begin
            slot_d = '0;
            if (req_init) begin
               gnt_d   = MASK_INIT;
               state_d = ST_GRANT;
            end else if (req_escr) begin
               gnt_d   = MASK_ESCR;
               state_d = ST_GRANT;
            end else if (lect_pend_q) begin
               gnt_d   = MASK_LECT;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            slot_d  = '0;
            state_d = ST_DIR;
         end
         ST_DIR: begin
            if (slot_q == LAST_DIR) begin
               slot_d  = '0;
               state_d = (T_GAP == 0) ? ST_DAT : ST_GAP;
            end else begin
               slot_d = slot_q + SW'(1);
            end
         end
         ST_GAP: begin
            if (slot_q == LAST_GAP) begin
               slot_d  = '0;
               state_d = ST_DAT;
            end else begin
               slot_d = slot_q + SW'(1);
            end
         end
         ST_DAT: begin
            if (slot_q == LAST_DAT) begin
               slot_d  = '0;
               state_d = ST_CAMBIO;
            end else begin
               slot_d = slot_q + SW'(1);
            end
         end
         ST_CAMBIO: begin
            slot_d  = '0;
            state_d = ST_DIR;
         end
         ST_RELEASE: begin
            gnt_d   = '0;
            slot_d  = '0;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            slot_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
      if (granted && (term_match || wd_expire)) begin
         gnt_d   = '0;
         slot_d  = '0;
         state_d = ST_RELEASE;
      end
   end

   // Scheduler state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         gnt_q          <= '0;
         slot_q         <= '0;
         lect_pend_q    <= 1'b0;
         lect_overrun_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         slot_q         <= slot_d;
         lect_pend_q    <= lect_pend_d;
         lect_overrun_q <= lect_overrun_d;
      end
   end

   assign gnt           = gnt_q;
   assign start         = (state_q == ST_GRANT) ? gnt_q : 3'b000;
   assign dir_ph        = (state_q == ST_DIR);
   assign dat_ph        = (state_q == ST_DAT);
   assign cambio_estado = (state_q == ST_CAMBIO);
   assign lect_overrun  = lect_overrun_q;

endmodule
